apb_slave_fifo_regs: RTL
========================

Name: apb_slave_fifo_regs

Overview:
- APB completer sitting directly downstream of the team's push-button APB master. It decodes paddr[6:0] into a small register bank plus a 16-entry byte FIFO window at 0x0C/0x2C.
- Provides data the master reads back into its own receive FIFO, and accepts the bytes it writes.
- Supports optional wait states and tolerates the master's one-cycle psel+penable access style.

Parameters:
- WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15).
- FIFO_DEPTH, 16, byte FIFO entries (power of 2).
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- prst  in  1  synchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  32  address; only [6:0] decoded, [31:7] ignored.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid while pready=1 on a read.
- pready  out  1  transfer complete.
- pslverr  out  1  error, valid with pready.
- irq  out  1  registered interrupt.

Behaviour:
- Reset (prst=1 at a pclk edge) sets the following: FSM=IDLE, wait counter=0, CTRL=0, SCRATCH=0, FIFO pointers=0, overflow=0, underflow=0, irq=0. Outputs are pready=0, pslverr=0, prdata=0. FIFO storage is not cleared. Reset mid-transfer aborts it with no register effect.
- Access: access = psel & penable.
- FSM states:
  - IDLE: on access with WAIT_STATES=0, complete in the same cycle (pready combinational =1), go to HOLD. On access with WAIT_STATES>0, load cnt=WAIT_STATES-1 and go to WAIT (pready=0).
  - WAIT: if access drops, go to IDLE with no side effect (abort). If cnt==0, pready=1, complete, go to HOLD. Otherwise cnt decrements.
  - HOLD: pready=0. Stay while access=1. Go to IDLE when access=0. This guarantees exactly one side effect per transfer even if the master holds penable high.
- Completion: all register/FIFO side effects occur at the pclk edge ending the cycle where access & pready=1.
- Register map (paddr[6:0]):
  - 0x00 CTRL RW [1:0]: bit0 = irq-on-not-empty enable, bit1 = irq-on-overflow enable. Reads return {30'b0, CTRL}.
  - 0x04 STATUS:
    - Read returns {23'b0, overflow, underflow, full, empty, count[4:0]}.
    - Write: bits [8] and [7] are write-1-to-clear; all other bits are ignored.
  - 0x08 SCRATCH RW 32-bit.
  - 0x0C FIFO:
    - Write pushes pwdata[7:0].
    - Read returns {24'b0, head} and pops.
  - 0x2C PEEK RO: returns {24'b0, head} without popping. Write is ignored with pslverr=1.
  - Any other address: read 0, write ignored, pslverr=1. pslverr=0 for all legal accesses.
- prdata is combinational from the decode while pready=1 and pwrite=0; it is 0 otherwise.
- FIFO:
  - Pointers are FIFO_AW+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full = MSBs differ and lower bits are equal.
  - empty = pointers are equal.
  - count = wptr - rptr (0..16).
- Push when full: data dropped, overflow set (sticky), pslverr=0.
- Pop when empty: returns 0x00, pointers unchanged, underflow set (sticky).
- PEEK when empty returns 0x00.
- W1C on the same edge as a new overflow/underflow event: the set wins.
- irq register = (CTRL[0] & ~empty) | (CTRL[1] & overflow). It updates one cycle after the cause.
- Reset takes priority over any transfer.

Test Plan:
- Reset, then read 0x04 -> prdata=0x0000_0020 (empty=1, count=0); irq=0; pslverr=0.
- WAIT_STATES=0: write 0x08=0xDEADBEEF, then read 0x08 -> pready high in the access cycle, prdata=0xDEADBEEF; single-cycle psel+penable bursts from the master complete.
- Push 0x11,0x22,0x33 to 0x0C; read 0x2C -> 0x11 with count still 3; read 0x0C three times -> 0x11,0x22,0x33; STATUS -> 0x20.
- Push 17 bytes (0x00..0x10) -> STATUS=0x150 (overflow=1, full=1, count=16). With CTRL=0x2, irq=1 one cycle later. Write 0x04 with 0x100 -> overflow=0, irq=0. Pop 16 -> 0x00..0x0F, and pointer wrap is correct.
- Pop when empty -> prdata=0, underflow=1. Write 0x2C and read 0x40 -> pslverr=1 with pready, no state change.
- WAIT_STATES=3: read 0x08 -> pready rises on the 4th access cycle. Drop penable after 2 cycles during a 0x0C read -> no pop, FSM=IDLE. Hold penable 5 cycles after completion -> exactly one pop.

Source files
------------

// File: rtl/apb_slave_fifo_regs.sv
// APB completer: CTRL/STATUS/SCRATCH registers plus a byte FIFO window with push/pop at 0x0C and peek at 0x2C.
// Optional wait states; the HOLD state ensures one side effect per transfer.
//  state   | meaning
//  IDLE    | no transfer in progress; completes at once when there are no wait states
//  WAIT    | counting down access-phase wait cycles, pready low
//  HOLD    | transfer done; waiting for the master to drop psel/penable
module apb_slave_fifo_regs #(
   parameter int WAIT_STATES = 0,
   parameter int FIFO_DEPTH  = 16,
   parameter int FIFO_AW     = 4
) (
   input  logic        pclk,
   input  logic        prst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        irq
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

   localparam bit             NO_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0]     WS_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);
   localparam logic [6:0]     A_CTRL  = 7'h00;
   localparam logic [6:0]     A_STAT  = 7'h04;
   localparam logic [6:0]     A_SCR   = 7'h08;
   localparam logic [6:0]     A_FIFO  = 7'h0C;
   localparam logic [6:0]     A_PEEK  = 7'h2C;

   state_t            state_q, state_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [31:0]       scratch_q, scratch_d;
   logic [FIFO_AW:0]  wptr_q, wptr_d;
   logic [FIFO_AW:0]  rptr_q, rptr_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              irq_q, irq_d;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic              access;
   logic              done;
   logic [6:0]        addr;
   logic              addr_ok;
   logic              fifo_empty;
   logic              fifo_full;
   logic [FIFO_AW:0]  fifo_cnt;
   logic [7:0]        head;
   logic [31:0]       status;
   logic [31:0]       rd_mux;
   logic              mem_we;
   logic              unused_paddr;

   assign access       = psel & penable;
   assign addr         = paddr[6:0];
   assign unused_paddr = ^paddr[31:7];

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                       (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign fifo_cnt   = wptr_q - rptr_q;
   assign head       = fifo_empty ? 8'h00 : mem_q[rptr_q[FIFO_AW-1:0]];
   assign status     = {23'b0, ovf_q, udf_q, fifo_full, fifo_empty, 5'(fifo_cnt)};

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               if (NO_WAIT) begin
                  pready  = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  wcnt_d  = WS_LOAD;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!access) begin
               state_d = ST_IDLE;
            end else if (wcnt_q == 4'd0) begin
               pready  = 1'b1;
               state_d = ST_HOLD;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (!access) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // reset wins over a transfer completing in the same cycle
      if (prst) pready = 1'b0;
   end

   assign done    = access & pready;
   assign addr_ok = (addr == A_CTRL) || (addr == A_STAT) || (addr == A_SCR) ||
                    (addr == A_FIFO) || (addr == A_PEEK);
   assign pslverr = pready & (~addr_ok | ((addr == A_PEEK) & pwrite));

   always_comb begin
      rd_mux = 32'h0;
      case (addr)
         A_CTRL:         rd_mux = {30'b0, ctrl_q};
         A_STAT:         rd_mux = status;
         A_SCR:          rd_mux = scratch_q;
         A_FIFO, A_PEEK: rd_mux = {24'b0, head};
         default:        rd_mux = 32'h0;
      endcase
   end

   assign prdata = (pready & ~pwrite) ? rd_mux : 32'h0;

   always_comb begin
      ctrl_d    = ctrl_q;
      scratch_d = scratch_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      mem_we    = 1'b0;
      if (done) begin
         if (pwrite) begin
            case (addr)
               A_CTRL: ctrl_d = pwdata[1:0];
               A_STAT: begin
                  if (pwdata[8]) ovf_d = 1'b0;
                  if (pwdata[7]) udf_d = 1'b0;
               end
               A_SCR:  scratch_d = pwdata;
               A_FIFO: begin
                  if (fifo_full) begin
                     ovf_d = 1'b1;
                  end else begin
                     mem_we = 1'b1;
                     wptr_d = wptr_q + PTR_ONE;
                  end
               end
               default: ;
            endcase
         end else if (addr == A_FIFO) begin
            if (fifo_empty) udf_d  = 1'b1;
            else            rptr_d = rptr_q + PTR_ONE;
         end
      end
      irq_d = (ctrl_q[0] & ~fifo_empty) | (ctrl_q[1] & ovf_q);
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q   <= ST_IDLE;
         wcnt_q    <= 4'd0;
         ctrl_q    <= 2'b0;
         scratch_q <= 32'h0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         ctrl_q    <= ctrl_d;
         scratch_q <= scratch_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         irq_q     <= irq_d;
      end
   end

   // storage is intentionally not reset
   always_ff @(posedge pclk) begin
      if (mem_we) mem_q[wptr_q[FIFO_AW-1:0]] <= pwdata[7:0];
   end

   assign irq = irq_q;

endmodule
